// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  // Arbiter FSM: IDLE means no grant was given last cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Requester identifier (0 or 1).
  typedef logic req_id_t;

  // Read-response tag carried alongside the macro access.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rsp_tag_t;

endpackage

// File: rtl/sram_arb_rsp_pipe.sv
// Two-stage response tag pipeline that routes the macro read data back to
// the requester that issued the read. Stage 2 lines up with mem_q.
module sram_arb_rsp_pipe
  import sram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_rd,
  input  req_id_t           issue_id,
  input  logic [DATA_W-1:0] mem_q,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  rsp_tag_t s1_q, s1_d;
  rsp_tag_t s2_q, s2_d;

  // Stage 1 captures the granted read, stage 2 follows stage 1.
  always_comb begin
    s1_d.valid = issue_rd;
    s1_d.id    = issue_id;
    s2_d       = s1_q;
  end

  // Tag registers; reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // Demux the macro output to the issuer; the other side sees zero.
  always_comb begin
    rvalid0 = s2_q.valid && (s2_q.id == 1'b0);
    rvalid1 = s2_q.valid && (s2_q.id == 1'b1);
    rdata0  = rvalid0 ? mem_q : '0;
    rdata1  = rvalid1 ? mem_q : '0;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port 1024x32 SRAM macro between two
// requesters, with bus locking bounded by MAX_BURST and registered macro
// inputs. Optional statistics counters are built when SRAM_ARB_STATS_EN is
// defined; otherwise the stat_* outputs are tied to zero.
//
// Handshake: reqN is held until gntN is high; the access (we/addr/wdata) is
// accepted in the cycle gntN is high. A read returns rvalidN/rdataN two
// cycles later; writes return nothing.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1,
  output logic [15:0]       stat_stall,
  output logic [1:0]        dbg_state
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  arb_state_e        state_q, state_d;
  req_id_t           last_id_q, last_id_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              mem_cen_q, mem_cen_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [DATA_W-1:0] mem_d_q, mem_d_d;

  logic    keep0, keep1, any_gnt, repeat_gnt, sel_we;
  req_id_t gnt_id;

  // Grant: locked owner keeps the bus unless it starves a waiting peer,
  // otherwise round-robin on ties and single requester wins outright.
  always_comb begin
    keep0 = (state_q == ST_OWN0) && req0 && lock0 && (!req1 || (burst_cnt_q < MAX_BURST_C));
    keep1 = (state_q == ST_OWN1) && req1 && lock1 && (!req0 || (burst_cnt_q < MAX_BURST_C));
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (keep0) begin
      gnt0 = 1'b1;
    end else if (keep1) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      gnt0 = (last_id_q == 1'b1);
      gnt1 = (last_id_q == 1'b0);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
    any_gnt    = gnt0 || gnt1;
    gnt_id     = gnt1;
    repeat_gnt = (gnt0 && (state_q == ST_OWN0)) || (gnt1 && (state_q == ST_OWN1));
  end

  // Next FSM state, round-robin pointer and burst counter.
  always_comb begin
    state_d     = gnt0 ? ST_OWN0 : (gnt1 ? ST_OWN1 : ST_IDLE);
    last_id_d   = any_gnt ? gnt_id : last_id_q;
    burst_cnt_d = burst_cnt_q;
    if (repeat_gnt) begin
      if (burst_cnt_q < MAX_BURST_C) begin
        burst_cnt_d = burst_cnt_q + 8'd1;
      end
    end else if (any_gnt) begin
      burst_cnt_d = 8'd1;
    end
  end

  // Macro command for the granted requester; address/data hold when idle.
  always_comb begin
    sel_we    = gnt_id ? we1 : we0;
    mem_cen_d = !any_gnt;
    mem_wen_d = any_gnt ? !sel_we : 1'b1;
    mem_a_d   = any_gnt ? (gnt_id ? addr1 : addr0) : mem_a_q;
    mem_d_d   = any_gnt ? (gnt_id ? wdata1 : wdata0) : mem_d_q;
  end

  // Arbiter state and registered macro inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_id_q   <= 1'b1;
      burst_cnt_q <= 8'd0;
      mem_cen_q   <= 1'b1;
      mem_wen_q   <= 1'b1;
      mem_a_q     <= '0;
      mem_d_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
      mem_cen_q   <= mem_cen_d;
      mem_wen_q   <= mem_wen_d;
      mem_a_q     <= mem_a_d;
      mem_d_q     <= mem_d_d;
    end
  end

  assign mem_cen   = mem_cen_q;
  assign mem_wen   = mem_wen_q;
  assign mem_a     = mem_a_q;
  assign mem_d     = mem_d_q;
  assign dbg_state = state_q;

  sram_arb_rsp_pipe u_rsp_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue_rd (any_gnt && !sel_we),
    .issue_id (gnt_id),
    .mem_q    (mem_q),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata0   (rdata0),
    .rdata1   (rdata1)
  );

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] stat_gnt0_q, stat_gnt0_d;
  logic [15:0] stat_gnt1_q, stat_gnt1_d;
  logic [15:0] stat_stall_q, stat_stall_d;
  logic        stall;

  // Saturating grant and stall counters.
  always_comb begin
    stall        = (req0 && !gnt0) || (req1 && !gnt1);
    stat_gnt0_d  = (gnt0 && (stat_gnt0_q != 16'hFFFF)) ? stat_gnt0_q + 16'd1 : stat_gnt0_q;
    stat_gnt1_d  = (gnt1 && (stat_gnt1_q != 16'hFFFF)) ? stat_gnt1_q + 16'd1 : stat_gnt1_q;
    stat_stall_d = (stall && (stat_stall_q != 16'hFFFF)) ? stat_stall_q + 16'd1 : stat_stall_q;
  end

  // Counters are cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt0_q  <= '0;
      stat_gnt1_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_gnt0_q  <= stat_gnt0_d;
      stat_gnt1_q  <= stat_gnt1_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_gnt0  = stat_gnt0_q;
  assign stat_gnt1  = stat_gnt1_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_gnt0  = '0;
  assign stat_gnt1  = '0;
  assign stat_stall = '0;
`endif

endmodule
